// File: rtl/peak_window_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// peak_window_detector : reduces WINDOW accepted audio samples to one 12-bit peak
// Revision 1.0
// ---------------------------------------------------------------------------
module peak_window_detector #(
   parameter int WINDOW    = 480,
   parameter int CNT_WIDTH = 10,
   parameter int SHIFT     = 3
) (
   input  logic        data_clk,
   input  logic        reset,
   input  logic [15:0] sample_data,
   input  logic        sample_valid,
   input  logic        enable,
   output logic [11:0] peak_data,
   output logic        peak_valid,
   output logic        clip
);

   localparam logic [CNT_WIDTH-1:0] c_last = CNT_WIDTH'(WINDOW - 1);
   localparam logic [CNT_WIDTH-1:0] c_one  = CNT_WIDTH'(1);

   logic [14:0]          w_neg;
   logic [14:0]          w_mag;
   logic [14:0]          w_scaled;
   logic [11:0]          w_sat;
   logic                 w_full;
   logic                 w_accept;
   logic [11:0]          w_max;

   logic [CNT_WIDTH-1:0] r_count;
   logic                 r_v1;
   logic [11:0]          r_m1;
   logic                 r_f1;
   logic                 r_last1;
   logic [11:0]          r_run;
   logic                 r_clip_acc;

   // -32768 has no positive 16-bit counterpart, so it is pinned to 32767
   assign w_neg = (~sample_data[14:0]) + 15'd1;

   always_comb begin
      w_mag = sample_data[14:0];
      if (sample_data[15]) begin
         if (sample_data[14:0] == 15'd0) begin
            w_mag = 15'h7FFF;
         end else begin
            w_mag = w_neg;
         end
      end
   end

   assign w_scaled = w_mag >> SHIFT;
   assign w_sat    = (w_scaled > 15'd4095) ? 12'hFFF : w_scaled[11:0];
   assign w_full   = (w_mag == 15'h7FFF);
   assign w_accept = sample_valid & enable;
   assign w_max    = (r_m1 > r_run) ? r_m1 : r_run;

   always_ff @(posedge data_clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (!enable) begin
         r_count <= '0;
      end else if (sample_valid) begin
         r_count <= (r_count == c_last) ? '0 : r_count + c_one;
      end
   end

   always_ff @(posedge data_clk or posedge reset) begin
      if (reset) begin
         r_v1    <= 1'b0;
         r_m1    <= '0;
         r_f1    <= 1'b0;
         r_last1 <= 1'b0;
      end else begin
         r_v1    <= w_accept;
         r_m1    <= w_sat;
         r_f1    <= w_full;
         r_last1 <= w_accept & (r_count == c_last);
      end
   end

   // A captured closing sample completes even when enable has just dropped
   always_ff @(posedge data_clk or posedge reset) begin
      if (reset) begin
         peak_data  <= '0;
         peak_valid <= 1'b0;
         clip       <= 1'b0;
         r_run      <= '0;
         r_clip_acc <= 1'b0;
      end else begin
         peak_valid <= 1'b0;
         if (r_v1 && r_last1) begin
            peak_data  <= w_max;
            clip       <= r_clip_acc | r_f1;
            peak_valid <= 1'b1;
            r_run      <= '0;
            r_clip_acc <= 1'b0;
         end else if (!enable) begin
            r_run      <= '0;
            r_clip_acc <= 1'b0;
         end else if (r_v1) begin
            r_run      <= w_max;
            r_clip_acc <= r_clip_acc | r_f1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_peak_window_detector.sv
`default_nettype none
// Bench for peak_window_detector: two instances (SHIFT=3, SHIFT=2), WINDOW=4.
module tb_peak_window_detector;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] sample_data = '0;
   logic        sample_valid = 1'b0;
   logic        enable = 1'b0;
   logic [11:0] pd3, pd2;
   logic        pv3, pv2, cl3, cl2;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      int cyc;
      int data;
      int clip;
   } ev_t;
   ev_t ev3[$];
   ev_t ev2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   peak_window_detector #(.WINDOW(4), .CNT_WIDTH(3), .SHIFT(3)) dut3 (
      .data_clk(clk), .reset(reset), .sample_data(sample_data), .sample_valid(sample_valid),
      .enable(enable), .peak_data(pd3), .peak_valid(pv3), .clip(cl3));

   peak_window_detector #(.WINDOW(4), .CNT_WIDTH(3), .SHIFT(2)) dut2 (
      .data_clk(clk), .reset(reset), .sample_data(sample_data), .sample_valid(sample_valid),
      .enable(enable), .peak_data(pd2), .peak_valid(pv2), .clip(cl2));

   always @(negedge clk) begin
      ev_t e;
      if (pv3) begin
         e.cyc = cyc; e.data = int'(pd3); e.clip = int'(cl3);
         ev3.push_back(e);
      end
      if (pv2) begin
         e.cyc = cyc; e.data = int'(pd2); e.clip = int'(cl2);
         ev2.push_back(e);
      end
   end

   // reference model: plain arithmetic on the window's sample values
   function automatic int sat_of(int s, int sh);
      int m;
      m = (s < 0) ? -s : s;
      if (m > 32767) m = 32767;
      m = m / (1 << sh);
      return (m > 4095) ? 4095 : m;
   endfunction

   function automatic int ref_peak(int w[4], int sh);
      int p = 0;
      foreach (w[i]) if (sat_of(w[i], sh) > p) p = sat_of(w[i], sh);
      return p;
   endfunction

   function automatic int ref_clip(int w[4]);
      int c = 0;
      foreach (w[i]) if (w[i] == 32767 || w[i] == -32768) c = 1;
      return c;
   endfunction

   function automatic int rnd_sample();
      case ($urandom_range(0, 7))
         0:       return 32767;
         1:       return -32768;
         default: return int'($urandom_range(0, 65535)) - 32768;
      endcase
   endfunction

   task automatic send(input int d, output int c);
      @(negedge clk);
      enable       = 1'b1;
      sample_valid = 1'b1;
      sample_data  = 16'(d);
      c = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         sample_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      #1;
      checks++; if (pd3 !== 12'd0) begin errors++; $display("FAIL reset_peak_data: got %0d expected 0", pd3); end
      checks++; if (pv3 !== 1'b0) begin errors++; $display("FAIL reset_peak_valid: got %0b expected 0", pv3); end
      checks++; if (cl3 !== 1'b0) begin errors++; $display("FAIL reset_clip: got %0b expected 0", cl3); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_basic();
      int c;
      ev3.delete();
      send(100, c); send(-2000, c); send(50, c); send(7, c);
      idle(4); #1;
      checks++; if (ev3.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", ev3.size()); end
      if (ev3.size() >= 1) begin
         checks++; if (ev3[0].data !== 250) begin errors++; $display("FAIL basic_peak: got %0d expected 250", ev3[0].data); end
         checks++; if (ev3[0].clip !== 0) begin errors++; $display("FAIL basic_clip: got %0d expected 0", ev3[0].clip); end
         checks++; if (ev3[0].cyc - c !== 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", ev3[0].cyc - c); end
      end
   endtask

   task automatic test_full_scale();
      int c;
      ev2.delete();
      send(10, c); send(-32768, c); send(5, c); send(5, c);
      repeat (4) send(40, c);
      idle(4); #1;
      checks++; if (ev2.size() !== 2) begin errors++; $display("FAIL full_count: got %0d expected 2", ev2.size()); end
      if (ev2.size() >= 2) begin
         checks++; if (ev2[0].data !== 4095) begin errors++; $display("FAIL full_peak: got %0d expected 4095", ev2[0].data); end
         checks++; if (ev2[0].clip !== 1) begin errors++; $display("FAIL full_clip: got %0d expected 1", ev2[0].clip); end
         checks++; if (ev2[1].data !== 10) begin errors++; $display("FAIL full_next_peak: got %0d expected 10", ev2[1].data); end
         checks++; if (ev2[1].clip !== 0) begin errors++; $display("FAIL full_next_clip: got %0d expected 0", ev2[1].clip); end
      end
   endtask

   task automatic test_back_to_back();
      int c;
      int seq[8] = '{800, 3, -5, 100, 16, -8, 1, 0};
      ev3.delete();
      foreach (seq[i]) send(seq[i], c);
      idle(4); #1;
      checks++; if (ev3.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", ev3.size()); end
      if (ev3.size() >= 2) begin
         checks++; if (ev3[0].data !== 100) begin errors++; $display("FAIL b2b_first: got %0d expected 100", ev3[0].data); end
         checks++; if (ev3[1].data !== 2) begin errors++; $display("FAIL b2b_second: got %0d expected 2", ev3[1].data); end
         checks++; if (ev3[1].cyc - ev3[0].cyc !== 4) begin errors++; $display("FAIL b2b_spacing: got %0d expected 4", ev3[1].cyc - ev3[0].cyc); end
      end
   endtask

   task automatic test_enable_flush();
      int c;
      ev3.delete();
      send(4000, c); send(4000, c);
      repeat (3) begin
         @(negedge clk);
         enable = 1'b0; sample_valid = 1'b1; sample_data = 16'd4000;
         #1;
         checks++; if (pd3 !== 12'd2) begin errors++; $display("FAIL flush_hold: got %0d expected 2", pd3); end
      end
      repeat (4) send(80, c);
      idle(4); #1;
      checks++; if (ev3.size() !== 1) begin errors++; $display("FAIL flush_count: got %0d expected 1", ev3.size()); end
      if (ev3.size() >= 1) begin
         checks++; if (ev3[0].data !== 10) begin errors++; $display("FAIL flush_peak: got %0d expected 10", ev3[0].data); end
      end
      // closing sample coincides with enable falling: nothing reported
      ev3.delete();
      send(80, c); send(80, c); send(80, c);
      @(negedge clk);
      enable = 1'b0; sample_valid = 1'b1; sample_data = 16'd4000;
      idle(4); #1;
      enable = 1'b1;
      checks++; if (ev3.size() !== 0) begin errors++; $display("FAIL drop_on_close_count: got %0d expected 0", ev3.size()); end
      checks++; if (pd3 !== 12'd10) begin errors++; $display("FAIL drop_on_close_hold: got %0d expected 10", pd3); end
   endtask

   task automatic test_gapped_reset();
      int c;
      int w[4];
      foreach (w[i]) w[i] = rnd_sample();
      w[1] = -int'($urandom_range(1000, 30000));
      ev3.delete();
      foreach (w[i]) begin
         send(w[i], c);
         if (i < 3) idle($urandom_range(0, 5));
      end
      idle(4); #1;
      checks++; if (ev3.size() !== 1) begin errors++; $display("FAIL gap_count: got %0d expected 1", ev3.size()); end
      if (ev3.size() >= 1) begin
         checks++; if (ev3[0].data !== ref_peak(w, 3)) begin errors++; $display("FAIL gap_peak: got %0d expected %0d", ev3[0].data, ref_peak(w, 3)); end
         checks++; if (ev3[0].clip !== ref_clip(w)) begin errors++; $display("FAIL gap_clip: got %0d expected %0d", ev3[0].clip, ref_clip(w)); end
      end
      send(4000, c); send(4000, c); send(4000, c);
      @(negedge clk);
      sample_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++; if (pd3 !== 12'd0) begin errors++; $display("FAIL async_reset_peak: got %0d expected 0", pd3); end
      checks++; if (cl3 !== 1'b0) begin errors++; $display("FAIL async_reset_clip: got %0b expected 0", cl3); end
      @(negedge clk);
      reset = 1'b0;
      ev3.delete();
      send(800, c); send(800, c); send(800, c);
      idle(3); #1;
      checks++; if (ev3.size() !== 0) begin errors++; $display("FAIL reset_restart_early: got %0d expected 0", ev3.size()); end
      send(800, c);
      idle(4); #1;
      checks++; if (ev3.size() !== 1) begin errors++; $display("FAIL reset_restart_count: got %0d expected 1", ev3.size()); end
      if (ev3.size() >= 1) begin
         checks++; if (ev3[0].data !== 100) begin errors++; $display("FAIL reset_restart_peak: got %0d expected 100", ev3[0].data); end
         checks++; if (ev3[0].cyc - c !== 2) begin errors++; $display("FAIL reset_restart_latency: got %0d expected 2", ev3[0].cyc - c); end
      end
   endtask

   task automatic test_random();
      int c;
      int w[4];
      int exp3[$], exp2[$], expc[$];
      ev3.delete(); ev2.delete();
      for (int n = 0; n < 12; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            send(rnd_sample(), c); send(rnd_sample(), c);
            repeat ($urandom_range(1, 2)) begin
               @(negedge clk);
               enable = 1'b0; sample_valid = 1'b1; sample_data = 16'h7FFF;
            end
         end
         foreach (w[i]) begin
            w[i] = rnd_sample();
            send(w[i], c);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
         end
         exp3.push_back(ref_peak(w, 3));
         exp2.push_back(ref_peak(w, 2));
         expc.push_back(ref_clip(w));
      end
      idle(4); #1;
      checks++; if (ev3.size() !== exp3.size()) begin errors++; $display("FAIL rand_count3: got %0d expected %0d", ev3.size(), exp3.size()); end
      checks++; if (ev2.size() !== exp2.size()) begin errors++; $display("FAIL rand_count2: got %0d expected %0d", ev2.size(), exp2.size()); end
      for (int i = 0; i < exp3.size() && i < ev3.size() && i < ev2.size(); i++) begin
         checks++; if (ev3[i].data !== exp3[i]) begin errors++; $display("FAIL rand_peak3[%0d]: got %0d expected %0d", i, ev3[i].data, exp3[i]); end
         checks++; if (ev2[i].data !== exp2[i]) begin errors++; $display("FAIL rand_peak2[%0d]: got %0d expected %0d", i, ev2[i].data, exp2[i]); end
         checks++; if (ev3[i].clip !== expc[i]) begin errors++; $display("FAIL rand_clip[%0d]: got %0d expected %0d", i, ev3[i].clip, expc[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_scale();
      test_back_to_back();
      test_enable_flush();
      test_gapped_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
